btn_ctrl: RTL and testbench

// Input-side front end for the counter/SSD display design: the user-input path into the counters.

---
 rtl/btn_ctrl.sv | 148 ++++++++++++++
 tb/tb_btn_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/btn_ctrl.sv
// Pushbutton front end: 2-FF synchronizers, per-button debounce FSMs, press pulses,
// a debounced reset level and three press-to-toggle enables.
module btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       btn_ctrl_clk,
    input  logic       btn_ctrl_rst_n,
    input  logic       btn_ctrl_btn_rst,
    input  logic       btn_ctrl_btn_hex,
    input  logic       btn_ctrl_btn_bcd,
    input  logic       btn_ctrl_btn_sel,
    output logic       btn_ctrl_rst_out,
    output logic       btn_ctrl_hex_en,
    output logic       btn_ctrl_bcd_en,
    output logic       btn_ctrl_sel,
    output logic [3:0] btn_ctrl_press
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int               NB       = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_LO, W_HI, S_HI, W_LO} state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0] press;
    logic [2:0]    tgl_q, tgl_d;

    // Bit order {sel, bcd, hex, rst} is shared by press pulses and synchronizers.
    assign raw = {btn_ctrl_btn_sel, btn_ctrl_btn_bcd, btn_ctrl_btn_hex, btn_ctrl_btn_rst};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        tgl_d   = tgl_q ^ press[3:1];
    end

    always_ff @(posedge btn_ctrl_clk or negedge btn_ctrl_rst_n) begin
        if (!btn_ctrl_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            tgl_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            tgl_q   <= tgl_d;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             prs_q, prs_d;
        logic             s;

        assign s = sync2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            prs_d   = 1'b0;
            case (state_q)
                S_LO: begin
                    if (s) begin
                        state_d = W_HI;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                W_HI: begin
                    if (!s) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_HI;
                        cnt_d   = '0;
                        prs_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HI: begin
                    if (!s) begin
                        state_d = W_LO;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                W_LO: begin
                    if (s) begin
                        state_d = S_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_LO;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge btn_ctrl_clk or negedge btn_ctrl_rst_n) begin
            if (!btn_ctrl_rst_n) begin
                state_q <= S_LO;
                cnt_q   <= '0;
                prs_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                prs_q   <= prs_d;
            end
        end

        assign press[i] = prs_q;

        // Only the reset button exports its debounced level; it is registered from the next state.
        if (i == 0) begin : g_lvl
            logic rst_out_q, rst_out_d;

            always_comb begin
                rst_out_d = (state_d == S_HI) || (state_d == W_LO);
            end

            always_ff @(posedge btn_ctrl_clk or negedge btn_ctrl_rst_n) begin
                if (!btn_ctrl_rst_n) begin
                    rst_out_q <= 1'b0;
                end else begin
                    rst_out_q <= rst_out_d;
                end
            end

            assign btn_ctrl_rst_out = rst_out_q;
        end
    end

    assign btn_ctrl_press  = press;
    assign btn_ctrl_hex_en = tgl_q[0];
    assign btn_ctrl_bcd_en = tgl_q[1];
    assign btn_ctrl_sel    = tgl_q[2];
endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with a short debounce window of 4 cycles.
module tb_btn_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_rst, btn_hex, btn_bcd, btn_sel;
    logic       rst_out, hex_en, bcd_en, sel;
    logic [3:0] press;

    int checks = 0;
    int errors = 0;
    int pulses;

    btn_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .btn_ctrl_clk     (clk),
        .btn_ctrl_rst_n   (rst_n),
        .btn_ctrl_btn_rst (btn_rst),
        .btn_ctrl_btn_hex (btn_hex),
        .btn_ctrl_btn_bcd (btn_bcd),
        .btn_ctrl_btn_sel (btn_sel),
        .btn_ctrl_rst_out (rst_out),
        .btn_ctrl_hex_en  (hex_en),
        .btn_ctrl_bcd_en  (bcd_en),
        .btn_ctrl_sel     (sel),
        .btn_ctrl_press   (press)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {1'b0, rst_out, hex_en, bcd_en, sel, press[2:0]} | {4'b0, press[3], 3'b0};
    endfunction

    initial begin
        // 1: reset with random buttons high, then release with buttons low
        rst_n = 1'b0;
        {btn_sel, btn_bcd, btn_hex, btn_rst} = 4'($urandom_range(1, 15));
        repeat (3) step();
        check("reset_outputs", {rst_out, hex_en, bcd_en, sel, press}, 8'h00);
        {btn_sel, btn_bcd, btn_hex, btn_rst} = 4'b0000;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("idle_after_reset", {rst_out, hex_en, bcd_en, sel, press}, 8'h00);

        // 2: hex press held; pulse 6 edges after raw rise, one toggle only
        btn_hex = 1'b1;
        repeat (5) step();
        check("hex_press_early", {4'b0, press}, 8'h00);
        step();
        check("hex_press_edge6", {4'b0, press}, 8'h02);
        step();
        check("hex_press_one_cycle", {4'b0, press}, 8'h00);
        check("hex_en_set", {7'b0, hex_en}, 8'h01);
        pulses = 0;
        repeat (15) begin
            step();
            if (press != 4'b0) pulses++;
        end
        check("hex_held_no_pulse", 8'(pulses), 8'h00);
        check("hex_en_held", {7'b0, hex_en}, 8'h01);
        btn_hex = 1'b0;
        pulses = 0;
        repeat (10) begin
            step();
            if (press != 4'b0) pulses++;
        end
        check("hex_release_no_pulse", 8'(pulses), 8'h00);
        check("hex_en_after_release", {7'b0, hex_en}, 8'h01);

        // 3: bcd bounce with highs of at most 3 cycles is rejected
        pulses = 0;
        btn_bcd = 1'b1; step(); if (press != 4'b0) pulses++;
        btn_bcd = 1'b0; step(); if (press != 4'b0) pulses++;
        btn_bcd = 1'b1;
        repeat (3) begin
            step();
            if (press != 4'b0) pulses++;
        end
        btn_bcd = 1'b0;
        repeat (12) begin
            step();
            if (press != 4'b0) pulses++;
        end
        check("bcd_bounce_no_pulse", 8'(pulses), 8'h00);
        check("bcd_bounce_en", {7'b0, bcd_en}, 8'h00);

        // 4: sel pressed, released, pressed again
        pulses = 0;
        btn_sel = 1'b1;
        repeat (10) begin
            step();
            if (press == 4'b1000) pulses++;
        end
        check("sel_first_pulses", 8'(pulses), 8'h01);
        check("sel_first_toggle", {7'b0, sel}, 8'h01);
        pulses = 0;
        btn_sel = 1'b0;
        repeat (10) begin
            step();
            if (press != 4'b0) pulses++;
        end
        check("sel_release_pulses", 8'(pulses), 8'h00);
        check("sel_after_release", {7'b0, sel}, 8'h01);
        pulses = 0;
        btn_sel = 1'b1;
        repeat (10) begin
            step();
            if (press == 4'b1000) pulses++;
        end
        check("sel_second_pulses", 8'(pulses), 8'h01);
        check("sel_second_toggle", {7'b0, sel}, 8'h00);
        btn_sel = 1'b0;
        repeat (10) step();

        // 5: hex and bcd rise together
        {btn_hex, btn_bcd} = 2'b11;
        repeat (5) step();
        check("dual_press_early", {4'b0, press}, 8'h00);
        step();
        check("dual_press_same_edge", {4'b0, press}, 8'h06);
        step();
        check("dual_toggles", {4'b0, rst_out, hex_en, bcd_en, sel}, 8'h02);
        {btn_hex, btn_bcd} = 2'b00;
        repeat (10) step();

        // 6: rst button level, toggles untouched
        btn_rst = 1'b1;
        repeat (5) step();
        check("rst_out_early", {7'b0, rst_out}, 8'h00);
        step();
        check("rst_out_rise", {7'b0, rst_out}, 8'h01);
        check("rst_press", {4'b0, press}, 8'h01);
        repeat (14) step();
        check("rst_held_toggles", {4'b0, rst_out, hex_en, bcd_en, sel}, 8'h0a);
        btn_rst = 1'b0;
        repeat (5) step();
        check("rst_out_fall_early", {7'b0, rst_out}, 8'h01);
        step();
        check("rst_out_fall", {7'b0, rst_out}, 8'h00);
        check("rst_after_toggles", {4'b0, rst_out, hex_en, bcd_en, sel}, 8'h02);

        // 6b: asynchronous reset while sel is held mid-count
        btn_sel = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("midcount_reset_clear", {rst_out, hex_en, bcd_en, sel, press}, 8'h00);
        repeat (2) step();
        check("midcount_reset_hold", {rst_out, hex_en, bcd_en, sel, press}, 8'h00);
        rst_n = 1'b1;
        repeat (5) step();
        check("rerun_press_early", {4'b0, press}, 8'h00);
        step();
        check("rerun_press", {4'b0, press}, 8'h08);
        step();
        check("rerun_sel_toggle", {4'b0, rst_out, hex_en, bcd_en, sel}, 8'h01);
        check("rerun_press_gone", {4'b0, press}, 8'h00);
        pulses = 0;
        repeat (10) begin
            step();
            if (press != 4'b0) pulses++;
        end
        check("rerun_single_pulse", 8'(pulses), 8'h00);
        check("final_outs", outs(), 8'h08);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
